// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the NCO: steps phi_inc, waits out NCO
// latency per step, then qualifies a dwell window of valid samples.
module nco_sweep_ctrl #(
  parameter int PHI_W   = 32,
  parameter int CNT_W   = 16,
  parameter int NCO_LAT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PHI_W-1:0] cfg_phi_start,
  input  logic [PHI_W-1:0] cfg_phi_step,
  input  logic [CNT_W-1:0] cfg_num_steps,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic             nco_out_valid,
  output logic [PHI_W-1:0] phi_inc_o,
  output logic             nco_clken,
  output logic             busy,
  output logic             seg_valid,
  output logic [CNT_W-1:0] step_idx,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [PHI_W-1:0] inc_q, inc_d;
  logic [PHI_W-1:0] phi_q, phi_d;
  logic             busy_q, busy_d;
  logic             seg_q, seg_d;
  logic             done_q, done_d;
  logic             settle_end, dwell_end, last_step;

  assign settle_end = (cnt_q == CNT_W'(NCO_LAT - 1));
  assign dwell_end  = (cnt_q == dwell_q - CNT_W'(1));
  assign last_step  = (idx_q == last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      idx_q   <= '0;
      inc_q   <= '0;
      phi_q   <= '0;
      busy_q  <= 1'b0;
      seg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      inc_q   <= inc_d;
      phi_q   <= phi_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start && !abort) state_d = SETTLE;
      SETTLE: if (abort) state_d = IDLE;
              else if (settle_end) state_d = DWELL;
      DWELL:  if (abort) state_d = IDLE;
              else if (dwell_end) state_d = last_step ? DONE : SETTLE;
      DONE:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    cnt_d   = (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
    last_d  = last_q;
    dwell_d = dwell_q;
    idx_d   = idx_q;
    inc_d   = inc_q;
    phi_d   = phi_q;
    if (state_q == IDLE && state_d == SETTLE) begin
      last_d  = (cfg_num_steps == '0) ? '0 : cfg_num_steps - CNT_W'(1);
      dwell_d = (cfg_dwell == '0) ? CNT_W'(1) : cfg_dwell;
      inc_d   = cfg_phi_step;
      phi_d   = cfg_phi_start;
      idx_d   = '0;
    end else if (state_q == DWELL && state_d == SETTLE) begin
      phi_d = phi_q + inc_q;
      idx_d = idx_q + CNT_W'(1);
    end
    busy_d = (state_d == SETTLE) || (state_d == DWELL);
    seg_d  = (state_d == DWELL) && nco_out_valid;
    done_d = (state_d == DONE);
  end

  assign phi_inc_o = phi_q;
  assign nco_clken = busy_q;
  assign busy      = busy_q;
  assign seg_valid = seg_q;
  assign step_idx  = idx_q;
  assign done      = done_q;

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer for the NCO core. Runs a programmed stepped-frequency sweep (chirp or hop list) by driving the NCO phase increment and clock enable. After each frequency change it waits out the NCO pipeline latency, then flags a dwell window during which NCO samples are valid for the current step. Sits between the host/config registers and the NCO instance, and feeds downstream capture logic with step-aligned qualifiers.

Parameters:
PHI_W, 32, width of phase increment (matches NCO phi_inc_i)
CNT_W, 16, width of step count, dwell count and step index
NCO_LAT, 8, cycles from phi_inc change until NCO output reflects it (1..255)

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; accepted only in IDLE
abort  in  1  terminate sweep; wins over start
cfg_phi_start  in  PHI_W  phase increment of step 0
cfg_phi_step  in  PHI_W  two's-complement increment added per step
cfg_num_steps  in  CNT_W  number of steps (0 treated as 1)
cfg_dwell  in  CNT_W  valid cycles per step (0 treated as 1)
nco_out_valid  in  1  out_valid from NCO
phi_inc_o  out  PHI_W  to NCO phi_inc_i
nco_clken  out  1  to NCO clken
busy  out  1  sweep in progress (SETTLE or DWELL)
seg_valid  out  1  NCO sample valid and settled for current step
step_idx  out  CNT_W  index of current step
done  out  1  one-cycle pulse on normal sweep completion

Behaviour:
- Reset (sync, high): state IDLE; phi_inc_o=0, nco_clken=0, busy=0, seg_valid=0, step_idx=0, done=0, all counters 0.
- States: IDLE, SETTLE, DWELL, DONE. All outputs registered.
- IDLE: nco_clken=0, phi_inc_o holds. When start=1 and abort=0, latch all cfg_* inputs; next cycle: SETTLE, phi_inc_o=cfg_phi_start, step_idx=0, busy=1, nco_clken=1. cfg_* changes after acceptance are ignored until the next start.
- SETTLE: lasts exactly NCO_LAT cycles, seg_valid=0, then DWELL.
- DWELL: lasts exactly max(cfg_dwell,1) cycles. seg_valid = nco_out_valid (registered alignment: seg_valid in cycle n reflects nco_out_valid sampled in cycle n-1, with DWELL qualification applied in the same cycle). The dwell counter advances every cycle regardless of nco_out_valid.
- End of DWELL: if step_idx == max(cfg_num_steps,1)-1, go to DONE. Otherwise, next cycle phi_inc_o += cfg_phi_step (modulo 2^PHI_W, wrap silently), step_idx += 1, and go to SETTLE.
- DONE: exactly 1 cycle; done=1, busy=0, nco_clken=0, seg_valid=0; then IDLE. start during DONE is ignored. phi_inc_o and step_idx hold the last values until the next accepted start.
- Per-step duration: NCO_LAT + dwell cycles. Total busy cycles: steps*(NCO_LAT+dwell).
- abort=1 in SETTLE/DWELL/DONE: next cycle IDLE, busy=0, seg_valid=0, nco_clken=0, no done pulse, phi_inc_o/step_idx hold. abort=1 in IDLE blocks start.
- Reset mid-sweep: same as power-on reset next cycle; no done pulse.

Test Plan:
- NCO_LAT=8, start=0x23D70A3D, step=0x01000000, steps=3, dwell=4, start pulse at cycle 0. Required: busy high cycles 1..36; phi_inc_o=0x23D70A3D, then 0x24D70A3D at cycle 13, then 0x25D70A3D at cycle 25; seg_valid high only in cycles 9-12, 21-24, 33-36 (nco_out_valid held 1); done=1 at cycle 37 only; IDLE at cycle 38.
- Wrap and negative step: start=0xFF000000, step=0x02000000, steps=2 gives a second step of 0x01000000. Start=0x00000010, step=0xFFFFFFF0, steps=2 gives a second step of 0x00000000.
- Zero config: steps=0, dwell=0. Required: single step, 8 SETTLE + 1 DWELL cycle, then a done pulse; busy high for exactly 9 cycles.
- Abort at the 2nd DWELL cycle of step 1. Required: IDLE next cycle, busy/seg_valid/nco_clken=0, done never pulses, step_idx=1 held. start+abort together in IDLE leaves the block in IDLE.
- nco_out_valid toggling 1,0,1,0 during DWELL. Required: seg_valid follows the toggling pattern only inside DWELL windows; the dwell length is unchanged. start during busy or DONE is ignored (phi sequence unaffected).
- reset asserted mid-SETTLE of step 2. Required: all outputs 0 next cycle; a new start afterwards runs the full sweep from step 0.
